// File: rtl/tap_pkg.sv
// Shared TAP definitions: data-register widths and the per-cycle DR operation
// derived from the controller strobes.
package tap_pkg;

   localparam int IDCODE_DR_W = 32;
   localparam int DEBUG_DR_W  = 41;

   typedef enum logic [1:0] {
      DR_IDLE,
      DR_CAPTURE,
      DR_SHIFT,
      DR_UPDATE
   } dr_op_e;

   // Capture wins over shift, shift over update; nothing happens unless selected.
   function automatic dr_op_e dr_op_decode(input logic sel, input logic cap,
                                           input logic sh, input logic upd);
      dr_op_e op;
      op = DR_IDLE;
      if (sel) begin
         if (cap)
            op = DR_CAPTURE;
         else if (sh)
            op = DR_SHIFT;
         else if (upd)
            op = DR_UPDATE;
      end
      return op;
   endfunction

endpackage

// File: rtl/tap_dr_counter.sv
// Saturating shifted-bit counter for a WIDTH-bit data register; eq_width flags
// a scan of exactly WIDTH bits.
module tap_dr_counter #(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic eq_width
);

   // Wide enough to hold the overlong marker WIDTH+1 for every WIDTH.
   localparam int CNT_W = $clog2(WIDTH + 2);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_q;
      if (clr)
         cnt_next = '0;
      else if (inc && (cnt_q != CNT_SAT))
         cnt_next = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_next;
   end

   assign eq_width = (cnt_q == CNT_FULL);

endmodule

// File: rtl/tap_data_reg.sv
// JTAG data register: WIDTH-bit capture/shift chain with a length-checked
// update stage and an integrated 1-bit bypass path.
module tap_data_reg
   import tap_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               LEN_CHECK = 1'b1
) (
   input  logic             tck_i,
   input  logic             trst_ni,
   input  logic             tdi_i,
   input  logic             select_i,
   input  logic             bypassEna_i,
   input  logic             captureDr_i,
   input  logic             shiftDr_i,
   input  logic             updateDr_i,
   input  logic [WIDTH-1:0] captureData_i,
   output logic             tdo_o,
   output logic [WIDTH-1:0] updateData_o,
   output logic             updateStrobe_o,
   output logic             lenError_o
);

   dr_op_e           op;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] update_q;
   logic             bypass_q;
   logic             armed_q;
   logic             tdo_q;
   logic             strobe_q;
   logic             len_err_q;
   logic             cnt_full;
   logic             len_ok;
   logic             upd_try;

   assign op      = dr_op_decode(select_i, captureDr_i, shiftDr_i, updateDr_i);
   assign len_ok  = !LEN_CHECK || cnt_full;
   // Only the first update after a capture acts, so a held strobe pulses once.
   assign upd_try = !bypassEna_i && (op == DR_UPDATE) && armed_q;

   tap_dr_counter #(
      .WIDTH(WIDTH)
   ) u_cnt (
      .clk      (tck_i),
      .rst_n    (trst_ni),
      .clr      (!bypassEna_i && (op == DR_CAPTURE)),
      .inc      (!bypassEna_i && (op == DR_SHIFT)),
      .eq_width (cnt_full)
   );

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         shift_q   <= '0;
         update_q  <= RESET_VAL;
         bypass_q  <= 1'b0;
         armed_q   <= 1'b0;
         tdo_q     <= 1'b0;
         strobe_q  <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         strobe_q <= upd_try && len_ok;
         if (select_i)
            tdo_q <= bypassEna_i ? bypass_q : shift_q[0];
         if (bypassEna_i) begin
            if (op == DR_CAPTURE)
               bypass_q <= 1'b0;
            else if (op == DR_SHIFT)
               bypass_q <= tdi_i;
         end else begin
            case (op)
               DR_CAPTURE: begin
                  shift_q <= captureData_i;
                  armed_q <= 1'b1;
               end
               DR_SHIFT:   shift_q <= {tdi_i, shift_q[WIDTH-1:1]};
               DR_UPDATE: begin
                  if (armed_q) begin
                     armed_q <= 1'b0;
                     if (len_ok) begin
                        update_q  <= shift_q;
                        len_err_q <= 1'b0;
                     end else begin
                        len_err_q <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign tdo_o          = tdo_q;
   assign updateData_o   = update_q;
   assign updateStrobe_o = strobe_q;
   assign lenError_o     = len_err_q;

endmodule
